// File: rtl/mesi_bus_pkg.sv
// Shared types for the MESI snoop bus arbiter: bus commands
// and arbiter FSM states.
package mesi_bus_pkg;

   typedef enum logic [1:0] {
      CMD_NONE = 2'd0,
      CMD_RD   = 2'd1,
      CMD_RDX  = 2'd2,
      CMD_UPGR = 2'd3
   } bus_cmd_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GRANT = 3'd1,
      SNOOP = 3'd2,
      FLUSH = 3'd3,
      MEM   = 3'd4,
      DONE  = 3'd5
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible bit at or
// after ptr, searching upward with wrap.
// Ports: elig (N), ptr (SW) in; gnt one-hot, idx, any out.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0]  elig,
   input  logic [SW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [SW-1:0] idx,
   output logic          any
);

   logic found;
   int   j;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!found && elig[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = j[SW-1:0];
         end
      end
   end

   assign any = |elig;

endmodule

// File: rtl/mesi_bus_arbiter.sv
// Snoop bus owner for NUM_CACHES MESI controllers: round-robin
// grant, command broadcast, snoop collection, flush/memory phase.
// Ports: req/req_cmd in, gnt/bus_* out, snoop_* in, mem_req/ack,
// flush_done in, done/c_out out, proto_err sticky out.
module mesi_bus_arbiter
   import mesi_bus_pkg::*;
#(
   parameter  int NUM_CACHES   = 4,
   parameter  int SNOOP_CYCLES = 2,
   localparam int SRC_W        = $clog2(NUM_CACHES)
) (
   input  logic                    clk,
   input  logic                    rstb,
   input  logic [NUM_CACHES-1:0]   req,
   input  logic [2*NUM_CACHES-1:0] req_cmd,
   output logic [NUM_CACHES-1:0]   gnt,
   output logic                    bus_valid,
   output logic [1:0]              bus_cmd,
   output logic [SRC_W-1:0]        bus_src,
   input  logic [NUM_CACHES-1:0]   snoop_shared,
   input  logic [NUM_CACHES-1:0]   snoop_flush,
   input  logic                    flush_done,
   output logic                    mem_req,
   input  logic                    mem_ack,
   output logic [NUM_CACHES-1:0]   done,
   output logic                    c_out,
   output logic                    proto_err
);

   localparam int CNT_W = $clog2(SNOOP_CYCLES + 1);

   arb_state_t             state_q, state_d;
   logic [SRC_W-1:0]       rr_q, rr_d;
   logic [SRC_W-1:0]       own_q, own_d;
   bus_cmd_t               cmd_q, cmd_d;
   logic [NUM_CACHES-1:0]  gnt_q, gnt_d;
   logic                   bus_valid_q, bus_valid_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   c_res_q, c_res_d;
   logic                   mem_req_q, mem_req_d;
   logic [NUM_CACHES-1:0]  done_q, done_d;
   logic                   c_out_q, c_out_d;
   logic                   perr_q, perr_d;

   logic [NUM_CACHES-1:0]  elig;
   logic [NUM_CACHES-1:0]  arb_gnt;
   logic [SRC_W-1:0]       arb_idx;
   logic                   arb_any;
   bus_cmd_t               win_cmd;
   logic [NUM_CACHES-1:0]  sh_m, fl_m;
   logic                   fl_multi;

   always_comb begin
      for (int i = 0; i < NUM_CACHES; i++) begin
         elig[i] = req[i] && (req_cmd[2*i +: 2] != CMD_NONE);
      end
   end

   rr_arbiter #(
      .N  (NUM_CACHES),
      .SW (SRC_W)
   ) u_rr (
      .elig (elig),
      .ptr  (rr_q),
      .gnt  (arb_gnt),
      .idx  (arb_idx),
      .any  (arb_any)
   );

   assign win_cmd = bus_cmd_t'(req_cmd[{arb_idx, 1'b0} +: 2]);

   // The owner's own snoop responses never count (gnt_q is its one-hot).
   assign sh_m     = snoop_shared & ~gnt_q;
   assign fl_m     = snoop_flush & ~gnt_q;
   // More than one bit set <=> clearing the lowest set bit leaves any.
   assign fl_multi = |(fl_m & (fl_m - 1'b1));

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      own_d       = own_q;
      cmd_d       = cmd_q;
      gnt_d       = gnt_q;
      bus_valid_d = 1'b0;
      cnt_d       = cnt_q;
      c_res_d     = c_res_q;
      mem_req_d   = mem_req_q;
      done_d      = '0;
      c_out_d     = 1'b0;
      perr_d      = perr_q;
      unique case (state_q)
         IDLE: begin
            if (arb_any) begin
               state_d     = GRANT;
               gnt_d       = arb_gnt;
               own_d       = arb_idx;
               cmd_d       = win_cmd;
               bus_valid_d = 1'b1;
            end
         end
         GRANT: begin
            state_d = SNOOP;
            cnt_d   = '0;
         end
         SNOOP: begin
            if (cnt_q == CNT_W'(SNOOP_CYCLES - 1)) begin
               c_res_d = (cmd_q == CMD_RD) && ((|sh_m) || (|fl_m));
               if (fl_multi) perr_d = 1'b1;
               if (cmd_q == CMD_UPGR) begin
                  state_d = DONE;
                  done_d  = gnt_q;
               end else if (|fl_m) begin
                  state_d = FLUSH;
               end else begin
                  state_d   = MEM;
                  mem_req_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FLUSH: begin
            if (flush_done) begin
               state_d = DONE;
               done_d  = gnt_q;
               c_out_d = c_res_q;
            end
         end
         MEM: begin
            if (mem_ack) begin
               state_d   = DONE;
               mem_req_d = 1'b0;
               done_d    = gnt_q;
               c_out_d   = c_res_q;
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
            rr_d    = (own_q == SRC_W'(NUM_CACHES - 1)) ?
                      '0 : own_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         own_q       <= '0;
         cmd_q       <= CMD_NONE;
         gnt_q       <= '0;
         bus_valid_q <= 1'b0;
         cnt_q       <= '0;
         c_res_q     <= 1'b0;
         mem_req_q   <= 1'b0;
         done_q      <= '0;
         c_out_q     <= 1'b0;
         perr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         own_q       <= own_d;
         cmd_q       <= cmd_d;
         gnt_q       <= gnt_d;
         bus_valid_q <= bus_valid_d;
         cnt_q       <= cnt_d;
         c_res_q     <= c_res_d;
         mem_req_q   <= mem_req_d;
         done_q      <= done_d;
         c_out_q     <= c_out_d;
         perr_q      <= perr_d;
      end
   end

   assign gnt       = gnt_q;
   assign bus_valid = bus_valid_q;
   assign bus_cmd   = cmd_q;
   assign bus_src   = own_q;
   assign mem_req   = mem_req_q;
   assign done      = done_q;
   assign c_out     = c_out_q;
   assign proto_err = perr_q;

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Directed bench for mesi_bus_arbiter (4 caches, 2 snoop cycles).
// Expected values are hand-derived per step.
module tb_mesi_bus_arbiter;

   logic       clk;
   logic       rstb;
   logic [3:0] req;
   logic [7:0] req_cmd;
   logic [3:0] gnt;
   logic       bus_valid;
   logic [1:0] bus_cmd;
   logic [1:0] bus_src;
   logic [3:0] snoop_shared;
   logic [3:0] snoop_flush;
   logic       flush_done;
   logic       mem_req;
   logic       mem_ack;
   logic [3:0] done;
   logic       c_out;
   logic       proto_err;

   int nchk = 0;
   int nerr = 0;
   int cyc;
   int w;
   int exp_src [5] = '{0, 2, 3, 0, 2};
   int exp_cmd [5] = '{1, 1, 2, 1, 1};

   mesi_bus_arbiter #(
      .NUM_CACHES   (4),
      .SNOOP_CYCLES (2)
   ) dut (
      .clk          (clk),
      .rstb         (rstb),
      .req          (req),
      .req_cmd      (req_cmd),
      .gnt          (gnt),
      .bus_valid    (bus_valid),
      .bus_cmd      (bus_cmd),
      .bus_src      (bus_src),
      .snoop_shared (snoop_shared),
      .snoop_flush  (snoop_flush),
      .flush_done   (flush_done),
      .mem_req      (mem_req),
      .mem_ack      (mem_ack),
      .done         (done),
      .c_out        (c_out),
      .proto_err    (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      while (done == 4'd0 && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic finish_txn();
      req          = '0;
      req_cmd      = '0;
      snoop_shared = '0;
      snoop_flush  = '0;
      flush_done   = 1'b0;
      mem_ack      = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rstb = 1'b0;
      tick();
      tick();
      rstb = 1'b1;
   endtask

   initial begin
      rstb = 1'b0;
      req = '0;
      req_cmd = '0;
      snoop_shared = '0;
      snoop_flush = '0;
      flush_done = 1'b0;
      mem_ack = 1'b0;
      tick();
      tick();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_bus_valid", 32'(bus_valid), 0);
      chk("rst_bus_cmd", 32'(bus_cmd), 0);
      chk("rst_bus_src", 32'(bus_src), 0);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_c_out", 32'(c_out), 0);
      chk("rst_proto_err", 32'(proto_err), 0);
      rstb = 1'b1;
      tick();

      // CMD_NONE request is never granted
      req = 4'b0001;
      req_cmd = 8'b0000_0000;
      tick();
      tick();
      chk("none_no_gnt", 32'(gnt), 0);
      chk("none_no_valid", 32'(bus_valid), 0);
      req = '0;
      tick();

      // T1: cache 1 RD, mem_ack in 3rd MEM cycle
      req = 4'b0010;
      req_cmd = 8'b0000_0100;
      tick();
      chk("t1_gnt", 32'(gnt), 32'h2);
      chk("t1_valid", 32'(bus_valid), 1);
      chk("t1_src", 32'(bus_src), 1);
      chk("t1_cmd", 32'(bus_cmd), 1);
      tick();
      chk("t1_valid_pulse", 32'(bus_valid), 0);
      chk("t1_gnt_hold", 32'(gnt), 32'h2);
      tick();
      chk("t1_snoop_no_mem", 32'(mem_req), 0);
      tick();
      chk("t1_mem1", 32'(mem_req), 1);
      tick();
      chk("t1_mem2", 32'(mem_req), 1);
      tick();
      chk("t1_mem3", 32'(mem_req), 1);
      chk("t1_no_done_yet", 32'(done), 0);
      mem_ack = 1'b1;
      tick();
      chk("t1_mem_drop", 32'(mem_req), 0);
      chk("t1_done", 32'(done), 32'h2);
      chk("t1_c_out", 32'(c_out), 0);
      finish_txn();
      chk("t1_done_pulse", 32'(done), 0);
      chk("t1_gnt_clear", 32'(gnt), 0);

      // T2: caches 0,2,3 requesting continuously, pointer 0
      do_reset();
      req = 4'b1101;
      req_cmd = 8'b1001_0001;
      mem_ack = 1'b1;
      for (int k = 0; k < 5; k++) begin
         w = 0;
         do begin
            tick();
            w++;
            chk("t2_onehot", 32'($countones(gnt) <= 1), 1);
         end while (!bus_valid && w < 20);
         chk("t2_grant_seen", 32'(bus_valid), 1);
         chk("t2_src", 32'(bus_src), 32'(exp_src[k]));
         chk("t2_gnt", 32'(gnt), 32'(1 << exp_src[k]));
         chk("t2_cmd", 32'(bus_cmd), 32'(exp_cmd[k]));
      end
      req = '0;
      req_cmd = '0;
      wait_done(20, cyc);
      chk("t2_last_done", 32'(done), 32'h4);
      finish_txn();

      // Uncontended RD latency: req -> done = 3 + SNOOP_CYCLES
      req = 4'b1000;
      req_cmd = 8'b0100_0000;
      mem_ack = 1'b1;
      wait_done(20, cyc);
      chk("lat_cycles", 32'(cyc), 5);
      chk("lat_done", 32'(done), 32'h8);
      finish_txn();

      // T3: cache 2 RD, cache 3 flushes and shares
      req = 4'b0100;
      req_cmd = 8'b0001_0000;
      snoop_shared = 4'b1000;
      snoop_flush = 4'b1000;
      tick();
      chk("t3_src", 32'(bus_src), 2);
      tick();
      tick();
      tick();
      chk("t3_flush_no_mem", 32'(mem_req), 0);
      chk("t3_flush_wait", 32'(done), 0);
      tick();
      chk("t3_flush_no_mem2", 32'(mem_req), 0);
      flush_done = 1'b1;
      tick();
      chk("t3_done", 32'(done), 32'h4);
      chk("t3_c_out", 32'(c_out), 1);
      chk("t3_mem_idle", 32'(mem_req), 0);
      chk("t3_no_perr", 32'(proto_err), 0);
      finish_txn();

      // T4: cache 0 UPGR, cache 1 shared -> straight to DONE
      req = 4'b0001;
      req_cmd = 8'b0000_0011;
      snoop_shared = 4'b0010;
      tick();
      chk("t4_cmd", 32'(bus_cmd), 3);
      tick();
      tick();
      tick();
      chk("t4_done", 32'(done), 32'h1);
      chk("t4_c_out", 32'(c_out), 0);
      chk("t4_no_mem", 32'(mem_req), 0);
      finish_txn();

      // T5a: owner 1 asserts its own shared/flush -> masked
      req = 4'b0010;
      req_cmd = 8'b0000_0100;
      snoop_shared = 4'b0010;
      snoop_flush = 4'b0010;
      mem_ack = 1'b1;
      wait_done(20, cyc);
      chk("t5a_cycles", 32'(cyc), 5);
      chk("t5a_done", 32'(done), 32'h2);
      chk("t5a_c_out", 32'(c_out), 0);
      chk("t5a_no_perr", 32'(proto_err), 0);
      finish_txn();

      // T5b: cache 0 RDX, two flushers (1 and 3)
      req = 4'b0001;
      req_cmd = 8'b0000_0010;
      snoop_flush = 4'b1010;
      flush_done = 1'b1;
      tick();
      tick();
      tick();
      chk("t5b_perr_not_yet", 32'(proto_err), 0);
      tick();
      chk("t5b_perr", 32'(proto_err), 1);
      chk("t5b_no_mem", 32'(mem_req), 0);
      tick();
      chk("t5b_done", 32'(done), 32'h1);
      chk("t5b_c_out", 32'(c_out), 0);
      finish_txn();

      // proto_err sticky across a clean transaction
      req = 4'b0001;
      req_cmd = 8'b0000_0001;
      mem_ack = 1'b1;
      wait_done(20, cyc);
      chk("sticky_done", 32'(done), 32'h1);
      finish_txn();
      chk("sticky_perr", 32'(proto_err), 1);

      // T6: async reset during MEM
      req = 4'b1000;
      req_cmd = 8'b0100_0000;
      tick();
      tick();
      tick();
      tick();
      chk("t6_in_mem", 32'(mem_req), 1);
      #3;
      rstb = 1'b0;
      #1;
      chk("t6_mem_req", 32'(mem_req), 0);
      chk("t6_gnt", 32'(gnt), 0);
      chk("t6_src", 32'(bus_src), 0);
      chk("t6_perr", 32'(proto_err), 0);
      chk("t6_done", 32'(done), 0);
      req = 4'b0011;
      req_cmd = 8'b0000_0101;
      tick();
      rstb = 1'b1;
      tick();
      chk("t6_regrant_src", 32'(bus_src), 0);
      chk("t6_regrant_gnt", 32'(gnt), 32'h1);
      req = '0;
      req_cmd = '0;
      mem_ack = 1'b1;
      wait_done(20, cyc);
      chk("t6_done_after", 32'(done), 32'h1);
      finish_txn();

      $display("Simulation finished: %0d checks, %0d errors",
               nchk, nerr);
      $finish;
   end

endmodule
